// File: rtl/fpwm_mc.sv
// fpwm_mc: multi-channel PWM generator programmed over an SPI slave port.
//
// A shared period counter drives CHANNELS set/clear compare pairs. RISE/FALL
// values are written into shadow registers and copied into the active
// compares on the counter wrap, so a compare update never produces a runt
// pulse. Each output has a force override, and o_Sync marks each wrap.
//
// SPI receiver states
//    state  | meaning
//    IDLE   | waiting for SS low (only after SS has been seen high)
//    HDR    | shifting in the 8-bit header (bit7 write, bits 6:0 index)
//    DATA   | shifting WIDTH data bits in (write) / out on MISO (read)
//    DONE   | frame complete; further SCK edges ignored until SS high
//
// Ports
//    i_Clk     system clock, rising edge
//    i_Reset   synchronous active-high reset
//    i_SCK     SPI clock (CPOL=0), asynchronous to i_Clk
//    i_MOSI    SPI data in, MSB first, sampled on SCK falling edge
//    i_SS      SPI select, active low
//    o_MISO    SPI readback data, registered
//    o_Pwm     PWM outputs, registered
//    o_Sync    one-cycle pulse on the counter wrap cycle
//
// Register map: 0 PERIOD, 1 CTRL (bit0 RUN), 2 FORCE_EN, 3 FORCE_VAL,
// 4+2k RISE[k], 5+2k FALL[k]. Unused indices read 0 and ignore writes.

module fpwm_mc #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
) (
   input  logic                i_Clk,
   input  logic                i_Reset,
   input  logic                i_SCK,
   input  logic                i_MOSI,
   input  logic                i_SS,
   output logic                o_MISO,
   output logic [CHANNELS-1:0] o_Pwm,
   output logic                o_Sync
);

   localparam int CW = 5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_DONE
   } spi_state_t;

   // ---------------------------------------------------------------------
   // SPI input synchronisers
   // ---------------------------------------------------------------------
   logic r_sck_s1, r_sck_s2, r_sck_h;
   logic r_mosi_s1, r_mosi_s2;
   logic r_ss_s1, r_ss_s2;

   logic w_sck_rise, w_sck_fall, w_mosi;

   assign w_sck_rise = r_sck_s2 & ~r_sck_h;
   assign w_sck_fall = ~r_sck_s2 & r_sck_h;
   assign w_mosi     = r_mosi_s2;

   // ---------------------------------------------------------------------
   // Register file
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0]    r_period;
   logic                r_run;
   logic [CHANNELS-1:0] r_force_en;
   logic [CHANNELS-1:0] r_force_val;
   logic [WIDTH-1:0]    r_rise_sh  [CHANNELS];
   logic [WIDTH-1:0]    r_fall_sh  [CHANNELS];
   logic [WIDTH-1:0]    r_rise_act [CHANNELS];
   logic [WIDTH-1:0]    r_fall_act [CHANNELS];

   // ---------------------------------------------------------------------
   // SPI receiver registers
   // ---------------------------------------------------------------------
   spi_state_t       r_state;
   logic             r_armed;
   logic [CW-1:0]    r_bit_cnt;
   logic [7:0]       r_hdr;
   logic [WIDTH-2:0] r_data;
   logic [WIDTH-2:0] r_tx;

   logic [6:0]       w_rd_idx;
   logic [WIDTH-1:0] w_rd_data;
   logic [WIDTH-1:0] w_data_shift;
   logic             w_wr_en;
   logic [6:0]       w_wr_idx;

   // Index is complete on the 8th header falling edge, before r_hdr holds it.
   assign w_rd_idx     = {r_hdr[5:0], w_mosi};
   assign w_data_shift = {r_data, w_mosi};
   assign w_wr_idx     = r_hdr[6:0];
   assign w_wr_en      = (r_state == S_DATA) && !r_ss_s2 && w_sck_fall &&
                         (r_bit_cnt == CW'(WIDTH - 1)) && r_hdr[7];

   always_comb begin
      w_rd_data = '0;
      if (w_rd_idx == 7'd0) begin
         w_rd_data = r_period;
      end else if (w_rd_idx == 7'd1) begin
         w_rd_data[0] = r_run;
      end else if (w_rd_idx == 7'd2) begin
         w_rd_data[CHANNELS-1:0] = r_force_en;
      end else if (w_rd_idx == 7'd3) begin
         w_rd_data[CHANNELS-1:0] = r_force_val;
      end
      for (int k = 0; k < CHANNELS; k++) begin
         if (w_rd_idx == 7'(4 + 2 * k)) w_rd_data = r_rise_sh[k];
         if (w_rd_idx == 7'(5 + 2 * k)) w_rd_data = r_fall_sh[k];
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_period    <= '0;
         r_run       <= 1'b0;
         r_force_en  <= '0;
         r_force_val <= '0;
         for (int k = 0; k < CHANNELS; k++) begin
            r_rise_sh[k] <= '0;
            r_fall_sh[k] <= '0;
         end
      end else if (w_wr_en) begin
         if (w_wr_idx == 7'd0) r_period <= w_data_shift;
         if (w_wr_idx == 7'd1) r_run <= w_data_shift[0];
         if (w_wr_idx == 7'd2) r_force_en <= w_data_shift[CHANNELS-1:0];
         if (w_wr_idx == 7'd3) r_force_val <= w_data_shift[CHANNELS-1:0];
         for (int k = 0; k < CHANNELS; k++) begin
            if (w_wr_idx == 7'(4 + 2 * k)) r_rise_sh[k] <= w_data_shift;
            if (w_wr_idx == 7'(5 + 2 * k)) r_fall_sh[k] <= w_data_shift;
         end
      end
   end

   // ---------------------------------------------------------------------
   // SPI receiver FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_sck_s1  <= 1'b0;
         r_sck_s2  <= 1'b0;
         r_sck_h   <= 1'b0;
         r_mosi_s1 <= 1'b0;
         r_mosi_s2 <= 1'b0;
         r_ss_s1   <= 1'b0;
         r_ss_s2   <= 1'b0;
         r_state   <= S_IDLE;
         r_armed   <= 1'b0;
         r_bit_cnt <= '0;
         r_hdr     <= '0;
         r_data    <= '0;
         r_tx      <= '0;
         o_MISO    <= 1'b0;
      end else begin
         r_sck_s1  <= i_SCK;
         r_sck_s2  <= r_sck_s1;
         r_sck_h   <= r_sck_s2;
         r_mosi_s1 <= i_MOSI;
         r_mosi_s2 <= r_mosi_s1;
         r_ss_s1   <= i_SS;
         r_ss_s2   <= r_ss_s1;

         // A frame may only start after SS has been seen deasserted, so a
         // select held low through reset cannot start mid-frame.
         if (r_ss_s2) r_armed <= 1'b1;

         if (r_ss_s2) begin
            r_state <= S_IDLE;
            o_MISO  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (r_armed) begin
                     r_state   <= S_HDR;
                     r_bit_cnt <= '0;
                  end
               end
               S_HDR: begin
                  if (w_sck_fall) begin
                     r_hdr <= {r_hdr[6:0], w_mosi};
                     if (r_bit_cnt == CW'(7)) begin
                        r_state   <= S_DATA;
                        r_bit_cnt <= '0;
                        r_tx      <= w_rd_data[WIDTH-2:0];
                        o_MISO    <= w_rd_data[WIDTH-1];
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                     end
                  end
               end
               S_DATA: begin
                  if (w_sck_rise) begin
                     o_MISO <= r_tx[WIDTH-2];
                     r_tx   <= r_tx << 1;
                  end
                  if (w_sck_fall) begin
                     r_data <= w_data_shift[WIDTH-2:0];
                     if (r_bit_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_DONE;
                        o_MISO  <= 1'b0;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------
   // Period counter and PWM channels
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0]    r_count;
   logic [CHANNELS-1:0] r_pwm_state;
   logic [CHANNELS-1:0] w_pwm_nxt;
   logic                w_wrap;

   // ">=" keeps the counter from running past a PERIOD lowered mid-period.
   assign w_wrap = r_run && (r_count >= r_period);

   always_comb begin
      w_pwm_nxt = r_pwm_state;
      for (int k = 0; k < CHANNELS; k++) begin
         if (!r_run) begin
            w_pwm_nxt[k] = 1'b0;
         end else if ((r_fall_act[k] <= r_period) && (r_count == r_fall_act[k])) begin
            w_pwm_nxt[k] = 1'b0;
         end else if ((r_rise_act[k] <= r_period) && (r_count == r_rise_act[k])) begin
            w_pwm_nxt[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_count     <= '0;
         r_pwm_state <= '0;
         o_Pwm       <= '0;
         o_Sync      <= 1'b0;
         for (int k = 0; k < CHANNELS; k++) begin
            r_rise_act[k] <= '0;
            r_fall_act[k] <= '0;
         end
      end else begin
         if (!r_run || w_wrap) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + 1'b1;
         end
         o_Sync <= w_wrap;

         if (!r_run || w_wrap) begin
            for (int k = 0; k < CHANNELS; k++) begin
               r_rise_act[k] <= r_rise_sh[k];
               r_fall_act[k] <= r_fall_sh[k];
            end
         end

         // Output takes the next state directly: one cycle after the match.
         r_pwm_state <= w_pwm_nxt;
         o_Pwm       <= (r_force_en & r_force_val) | (~r_force_en & w_pwm_nxt);
      end
   end

endmodule

// File: tb/tb_fpwm_mc.sv
// tb_fpwm_mc: directed self-checking bench for fpwm_mc (WIDTH=8, CHANNELS=4).

module tb_fpwm_mc;

   localparam int WIDTH    = 8;
   localparam int CHANNELS = 4;
   localparam int TH       = 40;

   logic                i_Clk;
   logic                i_Reset;
   logic                i_SCK;
   logic                i_MOSI;
   logic                i_SS;
   logic                o_MISO;
   logic [CHANNELS-1:0] o_Pwm;
   logic                o_Sync;

   int n_chk  = 0;
   int n_fail = 0;

   fpwm_mc #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .i_SCK   (i_SCK),
      .i_MOSI  (i_MOSI),
      .i_SS    (i_SS),
      .o_MISO  (o_MISO),
      .o_Pwm   (o_Pwm),
      .o_Sync  (o_Sync)
   );

   initial begin
      i_Clk = 1'b0;
      forever #5 i_Clk = ~i_Clk;
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic spi_bit(input logic b, output logic m);
      i_MOSI = b;
      #(TH);
      m = o_MISO;
      i_SCK = 1'b1;
      #(TH);
      i_SCK = 1'b0;
      #(TH);
   endtask

   task automatic spi_xfer(input logic [7:0] hdr, input logic [7:0] dat, output logic [7:0] rd);
      logic m;
      i_SS = 1'b0;
      #(2 * TH);
      for (int i = 7; i >= 0; i--) spi_bit(hdr[i], m);
      for (int i = 7; i >= 0; i--) begin
         spi_bit(dat[i], m);
         rd[i] = m;
      end
      i_SS = 1'b1;
      #(2 * TH);
   endtask

   task automatic reg_wr(input logic [6:0] idx, input logic [7:0] dat);
      logic [7:0] rd;
      spi_xfer({1'b1, idx}, dat, rd);
   endtask

   task automatic reg_rd(input logic [6:0] idx, output logic [7:0] rd);
      spi_xfer({1'b0, idx}, 8'h00, rd);
   endtask

   task automatic wait_sync();
      int n = 0;
      @(negedge i_Clk);
      while (o_Sync !== 1'b1 && n < 50) begin
         @(negedge i_Clk);
         n++;
      end
      check_val("sync_seen", 32'(o_Sync), 32'd1);
   endtask

   // Current sample is offset 0 (sync cycle); channel 0 expected high lo..hi.
   task automatic check_period(input int lo, input int hi);
      for (int off = 0; off < 10; off++) begin
         if (off > 0) @(negedge i_Clk);
         check_val("pwm0_shape", 32'(o_Pwm[0]), 32'((off >= lo && off <= hi) ? 1 : 0));
         check_val("sync_shape", 32'(o_Sync), 32'((off == 0) ? 1 : 0));
      end
   endtask

   initial begin
      logic [7:0] rd;
      logic       m;
      int         n;

      i_Reset = 1'b1;
      i_SCK   = 1'b0;
      i_MOSI  = 1'b0;
      i_SS    = 1'b0;

      // 1: reset with SS low and SCK toggling; frame ignored until SS cycles
      repeat (3) begin
         @(negedge i_Clk);
         i_SCK = ~i_SCK;
      end
      @(negedge i_Clk);
      i_SCK   = 1'b0;
      i_Reset = 1'b0;
      @(negedge i_Clk);
      check_val("rst_pwm", 32'(o_Pwm), 32'd0);
      check_val("rst_sync", 32'(o_Sync), 32'd0);
      check_val("rst_miso", 32'(o_MISO), 32'd0);
      for (int i = 7; i >= 0; i--) spi_bit(m, m);
      for (int i = 15; i >= 0; i--) begin
         rd = 8'h80;
         if (i < 8) rd = 8'h33;
         spi_bit(rd[i % 8], m);
      end
      i_SS = 1'b1;
      #(4 * TH);
      reg_rd(7'd0, rd);
      check_val("unarmed_period", 32'(rd), 32'h00);

      // 2: basic PWM, PERIOD=9 RISE0=2 FALL0=7
      reg_wr(7'd0, 8'd9);
      reg_wr(7'd4, 8'd2);
      reg_wr(7'd5, 8'd7);
      reg_rd(7'd0, rd);
      check_val("rd_period", 32'(rd), 32'd9);
      reg_wr(7'd1, 8'd1);
      reg_rd(7'd1, rd);
      check_val("rd_ctrl", 32'(rd), 32'd1);
      wait_sync();
      check_period(3, 7);
      @(negedge i_Clk);
      check_period(3, 7);

      // 3: FALL0=4 committed mid-period; takes effect next period only
      i_SS = 1'b0;
      #(2 * TH);
      rd = 8'h85;
      for (int i = 7; i >= 0; i--) spi_bit(rd[i], m);
      rd = 8'h04;
      for (int i = 7; i >= 1; i--) spi_bit(rd[i], m);
      i_MOSI = rd[0];
      #(TH);
      i_SCK = 1'b1;
      #(TH);
      wait_sync();
      i_SCK = 1'b0;
      for (int off = 1; off < 10; off++) begin
         @(negedge i_Clk);
         check_val("pwm0_cur", 32'(o_Pwm[0]), 32'((off >= 3 && off <= 7) ? 1 : 0));
      end
      @(negedge i_Clk);
      check_period(3, 4);
      @(negedge i_Clk);
      check_period(3, 4);
      i_SS = 1'b1;
      #(2 * TH);

      // 4: force override, independent of RUN
      reg_wr(7'd2, 8'h02);
      reg_wr(7'd3, 8'h02);
      reg_wr(7'd1, 8'h00);
      for (int i = 0; i < 5; i++) begin
         @(negedge i_Clk);
         check_val("force_on", 32'(o_Pwm), 32'h2);
      end
      reg_wr(7'd2, 8'h00);
      for (int i = 0; i < 3; i++) begin
         @(negedge i_Clk);
         check_val("force_off", 32'(o_Pwm), 32'h0);
      end

      // 5: readback
      reg_wr(7'd4, 8'h5A);
      reg_rd(7'd4, rd);
      check_val("rd_rise0", 32'(rd), 32'h5A);
      reg_rd(7'h7F, rd);
      check_val("rd_7f", 32'(rd), 32'h00);
      reg_rd(7'd5, rd);
      check_val("rd_fall0", 32'(rd), 32'h04);
      reg_rd(7'd3, rd);
      check_val("rd_fval", 32'(rd), 32'h02);

      // 6: partial frame ignored; RISE==FALL keeps output low
      reg_wr(7'd6, 8'h11);
      i_SS = 1'b0;
      #(2 * TH);
      rd = 8'h86;
      for (int i = 7; i >= 0; i--) spi_bit(rd[i], m);
      for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
      i_SS = 1'b1;
      #(2 * TH);
      reg_rd(7'd6, rd);
      check_val("partial_rise1", 32'(rd), 32'h11);
      reg_wr(7'd6, 8'd3);
      reg_wr(7'd7, 8'd3);
      reg_wr(7'd1, 8'd1);
      wait_sync();
      for (int i = 0; i < 20; i++) begin
         @(negedge i_Clk);
         check_val("eq_cmp_low", 32'(o_Pwm), 32'h0);
      end

      // PERIOD=0: every cycle is a wrap
      reg_wr(7'd0, 8'd0);
      n = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge i_Clk);
         check_val("period0_sync", 32'(o_Sync), 32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
